// File: rtl/conv_state_ctrl_pkg.sv
// rtl/conv_state_ctrl_pkg.sv - state codes and default geometry shared by the conv sequencer and its consumers
package conv_state_ctrl_pkg;

  localparam int STATE_W = 3;

  // The weight buffer treats STATE_HOLD as "hold ROM address, output 0".
  typedef enum logic [STATE_W-1:0] {
    STATE_IDLE    = 3'd0,
    STATE_PRELOAD = 3'd1,
    STATE_LOAD    = 3'd2,
    STATE_SHIFT   = 3'd3,
    STATE_BIAS    = 3'd4,
    STATE_DONE    = 3'd5,
    STATE_HOLD    = 3'd6
  } state_e;

  localparam int DEF_KERNEL_SIZE    = 3;
  localparam int DEF_PRELOAD_CYCLES = 4;
  localparam int DEF_LOAD_CYCLES    = 2;
  localparam int DEF_OUT_ROWS       = 2;
  localparam int DEF_KERNEL_NUM     = 2;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_phase(input int pre, input int load, input int ksz);
    int m;
    m = ksz * ksz;
    if (pre > m) m = pre;
    if (load > m) m = load;
    return m;
  endfunction

endpackage

// File: rtl/conv_state_ctrl_if.sv
// rtl/conv_state_ctrl_if.sv - start/abort/stall handshake and sequencer outputs
interface conv_state_ctrl_if #(
  parameter int ROW_W = 1,
  parameter int KER_W = 1
);
  import conv_state_ctrl_pkg::*;

  logic               i_start;
  logic               i_abort;
  logic               i_stall;
  logic [STATE_W-1:0] current_state;
  logic [ROW_W-1:0]   o_row_idx;
  logic [KER_W-1:0]   o_kernel_idx;
  logic               o_acc_clear;
  logic               o_acc_valid;
  logic               o_busy;
  logic               o_done;

  modport master (
    output i_start, i_abort, i_stall,
    input  current_state, o_row_idx, o_kernel_idx, o_acc_clear, o_acc_valid, o_busy, o_done
  );

  modport slave (
    input  i_start, i_abort, i_stall,
    output current_state, o_row_idx, o_kernel_idx, o_acc_clear, o_acc_valid, o_busy, o_done
  );

endinterface

// File: rtl/conv_state_ctrl_phase_counter.sv
// rtl/conv_state_ctrl_phase_counter.sv - loadable down-counter with enable and zero flag
module conv_phase_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && !zero) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/conv_state_ctrl.sv
// rtl/conv_state_ctrl.sv - PRELOAD/LOAD/SHIFT/BIAS sequencer for one conv layer pass
// Optional stall path (HOLD state) built only when CONV_CTRL_STALL_EN is defined.
module conv_state_ctrl #(
  parameter int KERNEL_SIZE    = conv_state_ctrl_pkg::DEF_KERNEL_SIZE,
  parameter int PRELOAD_CYCLES = conv_state_ctrl_pkg::DEF_PRELOAD_CYCLES,
  parameter int LOAD_CYCLES    = conv_state_ctrl_pkg::DEF_LOAD_CYCLES,
  parameter int OUT_ROWS       = conv_state_ctrl_pkg::DEF_OUT_ROWS,
  parameter int KERNEL_NUM     = conv_state_ctrl_pkg::DEF_KERNEL_NUM
) (
  input logic              clk,
  input logic              rst_n,
  conv_state_ctrl_if.slave bus
);
  import conv_state_ctrl_pkg::*;

  localparam int ROW_W = idx_width(OUT_ROWS);
  localparam int KER_W = idx_width(KERNEL_NUM);
  localparam int CNT_W = idx_width(max_phase(PRELOAD_CYCLES, LOAD_CYCLES, KERNEL_SIZE));

  localparam logic [CNT_W-1:0] PRE_LD   = CNT_W'(PRELOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_LD  = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHIFT_LD = CNT_W'(KERNEL_SIZE * KERNEL_SIZE - 1);

  state_e           state_q;
  logic [ROW_W-1:0] row_q;
  logic [KER_W-1:0] kernel_q;
  logic             acc_clear_q;
  logic             acc_valid_q;
  logic             busy_q;
  logic             done_q;

  logic             cnt_load;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_val;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             stall_take;
  logic             last_row;
  logic             last_kernel;

  assign last_row    = (row_q == ROW_W'(OUT_ROWS - 1));
  assign last_kernel = (kernel_q == KER_W'(KERNEL_NUM - 1));

`ifdef CONV_CTRL_STALL_EN
  state_e           saved_state_q;
  logic [CNT_W-1:0] saved_cnt_q;

  assign stall_take = bus.i_stall && !bus.i_abort &&
                      (state_q == STATE_SHIFT || state_q == STATE_BIAS);
`else
  logic unused_stall;

  assign unused_stall = bus.i_stall;
  assign stall_take   = 1'b0;
`endif

  conv_phase_counter #(.WIDTH(CNT_W)) u_phase_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (cnt_load),
    .en         (cnt_en),
    .load_value (cnt_val),
    .count      (cnt),
    .zero       (cnt_zero)
  );

  // Counter is reloaded on every state entry; a stalled cycle does not consume a count.
  always_comb begin
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = '0;
    if (!bus.i_abort) begin
      case (state_q)
        STATE_IDLE: if (bus.i_start) begin
          cnt_load = 1'b1;
          cnt_val  = PRE_LD;
        end
        STATE_PRELOAD: if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = LOAD_LD;
        end else cnt_en = 1'b1;
        STATE_LOAD: if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = SHIFT_LD;
        end else cnt_en = 1'b1;
        STATE_SHIFT: if (!stall_take) begin
          if (cnt_zero) cnt_load = 1'b1;
          else cnt_en = 1'b1;
        end
        STATE_BIAS: if (!stall_take) begin
          cnt_load = 1'b1;
          cnt_val  = last_row ? PRE_LD : LOAD_LD;
        end
`ifdef CONV_CTRL_STALL_EN
        STATE_HOLD: if (!bus.i_stall) begin
          cnt_load = 1'b1;
          cnt_val  = saved_cnt_q;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= STATE_IDLE;
      row_q         <= '0;
      kernel_q      <= '0;
      acc_clear_q   <= 1'b0;
      acc_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef CONV_CTRL_STALL_EN
      saved_state_q <= STATE_IDLE;
      saved_cnt_q   <= '0;
`endif
    end else begin
      acc_clear_q <= 1'b0;
      done_q      <= 1'b0;
      acc_valid_q <= (state_q == STATE_SHIFT || state_q == STATE_BIAS) &&
                     !stall_take && !bus.i_abort;
      if (bus.i_abort) begin
        state_q  <= STATE_IDLE;
        row_q    <= '0;
        kernel_q <= '0;
        busy_q   <= 1'b0;
      end else if (stall_take) begin
`ifdef CONV_CTRL_STALL_EN
        state_q       <= STATE_HOLD;
        saved_state_q <= state_q;
        saved_cnt_q   <= cnt;
`endif
      end else begin
        case (state_q)
          STATE_IDLE: if (bus.i_start) begin
            state_q  <= STATE_PRELOAD;
            row_q    <= '0;
            kernel_q <= '0;
            busy_q   <= 1'b1;
          end
          STATE_PRELOAD: if (cnt_zero) begin
            state_q     <= STATE_LOAD;
            acc_clear_q <= 1'b1;
          end
          STATE_LOAD: if (cnt_zero) state_q <= STATE_SHIFT;
          STATE_SHIFT: if (cnt_zero) state_q <= STATE_BIAS;
          STATE_BIAS: begin
            if (!last_row) begin
              state_q     <= STATE_LOAD;
              row_q       <= row_q + ROW_W'(1);
              acc_clear_q <= 1'b1;
            end else if (!last_kernel) begin
              state_q  <= STATE_PRELOAD;
              row_q    <= '0;
              kernel_q <= kernel_q + KER_W'(1);
            end else begin
              state_q <= STATE_DONE;
              done_q  <= 1'b1;
            end
          end
          STATE_DONE: begin
            state_q  <= STATE_IDLE;
            row_q    <= '0;
            kernel_q <= '0;
            busy_q   <= 1'b0;
          end
`ifdef CONV_CTRL_STALL_EN
          STATE_HOLD: if (!bus.i_stall) state_q <= saved_state_q;
`endif
          default: begin
            state_q  <= STATE_IDLE;
            row_q    <= '0;
            kernel_q <= '0;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.current_state = state_q;
  assign bus.o_row_idx     = row_q;
  assign bus.o_kernel_idx  = kernel_q;
  assign bus.o_acc_clear   = acc_clear_q;
  assign bus.o_acc_valid   = acc_valid_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_done        = done_q;

endmodule
